edge_frame_sequencer: RTL
=========================

Name: edge_frame_sequencer

Overview:
- Sequences one frame through the edge-detection datapath using the frame config held in the AHB slave register file: start read/write base addresses, width and height.
- Walks the image in row-major order, one pixel at a time:
  - fetches the pixel over a simple req/ack memory port;
  - hands it to the datapath;
  - waits for the datapath result;
  - writes the result back at the matching write address.
- Raises a one-cycle done pulse when the frame completes; the slave's done input is driven from it.

Parameters:
- PIX_BYTES, 4, address stride per pixel in bytes.
- RES_TIMEOUT, 255, maximum cycles to wait for res_valid before aborting with err.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request to begin a frame
- start_raddr  in  32  read base address
- start_waddr  in  32  write base address
- img_width  in  16  pixels per row
- img_height  in  16  rows per frame
- mem_req  out  1  memory access request
- mem_wr  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_addr  out  32  access address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data; valid when mem_ack=1
- mem_ack  in  1  access complete
- pix_valid  out  1  one-cycle strobe, pixel to datapath
- pix_data  out  32  pixel value
- res_valid  in  1  datapath result strobe
- res_data  in  32  datapath result
- busy  out  1  frame in progress
- done  out  1  one-cycle frame-complete pulse
- err  out  1  sticky error flag; cleared by next accepted start

Behaviour:
- Reset values (async, on rst=1): state IDLE; mem_req, mem_wr, pix_valid, busy, done, err all 0; mem_addr, mem_wdata, pix_data 0; x and y counters 0.
- IDLE:
  - start=1 latches start_raddr, start_waddr, img_width and img_height.
  - Clears err and sets busy the same edge.
  - Next state CHECK.
- CHECK:
  - Width or height equal to 0: set err, go to DONE.
  - Otherwise load rd_ptr=raddr and wr_ptr=waddr, go to RD.
- RD:
  - Drive mem_req=1, mem_wr=0, mem_addr=rd_ptr.
  - Hold all three stable until mem_ack.
  - On mem_ack: capture mem_rdata into pix_data, drop mem_req the next cycle, go to PUSH.
- PUSH: pix_valid=1 for exactly one cycle; clear the timeout counter; go to WAIT_RES.
- WAIT_RES:
  - On res_valid: capture res_data into mem_wdata, go to WR.
  - The counter increments each cycle without res_valid. When it reaches RES_TIMEOUT, set err and go to DONE (remaining pixels are not written).
  - res_valid arriving in any other state is ignored.
- WR:
  - Drive mem_req=1, mem_wr=1, mem_addr=wr_ptr, mem_wdata held stable until mem_ack.
  - On mem_ack go to ADV.
- ADV:
  - Add PIX_BYTES to rd_ptr and wr_ptr, each modulo 2^32 (wrap silently).
  - Increment x. When x = width-1, reset x to 0 and increment y.
  - Last pixel (x = width-1 and y = height-1): go to DONE. Otherwise go to RD.
- DONE: done=1 for one cycle, busy=0 the following cycle, return to IDLE.
- Minimum cost per pixel, with zero-wait ack and res_valid in the cycle after PUSH: RD 1 + PUSH 1 + WAIT_RES 1 + WR 1 + ADV 1 = 5 cycles.
- start while busy=1 is ignored, and the latched config is unaffected.
- Config inputs changing mid-frame have no effect.
- mem_ack outside RD/WR is ignored.
- rst mid-frame aborts immediately: no done pulse, and the outstanding mem_req drops asynchronously.
- Counters are 16 bits, so a 65535x65535 frame is supported without overflow.

Decomposition:
- Shared package edge_pkg holds:
  - the state enum seq_state_t (IDLE, CHECK, RD, PUSH, WAIT_RES, WR, ADV, DONE);
  - ADDR_W=32, DIM_W=16, DATA_W=32.
- One natural sub-module, frame_addr_gen:
  - holds the x/y counters and rd_ptr/wr_ptr;
  - takes load and advance strobes;
  - outputs last_pix.

Test Plan:
- 2x2 frame, raddr=0x1000, waddr=0x2000, zero-wait ack, res_data = pix+1 -> read addresses 0x1000/04/08/0C in order, each write to 0x2000+k*4 carries read value+1, single done pulse, busy low after, err=0.
- img_width=0, start=1 -> no mem_req, err=1, done pulse 2 cycles after start.
- 3x1 frame, raddr=0xFFFFFFFC -> read addresses 0xFFFFFFFC, 0x00000000, 0x00000004 (wrap).
- Datapath silent for 255 cycles after the first PUSH -> err=1, done pulse, exactly zero writes issued.
- start re-asserted mid-frame with different width -> ignored, frame completes with the original count; 3-cycle mem_ack delay -> mem_addr/mem_wr/mem_wdata held stable throughout.
- rst asserted during a WR with mem_req=1 -> mem_req=0 immediately, busy=0, done never pulses; a subsequent start runs a full frame correctly.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared types and widths for the edge-detection frame sequencer.
package edge_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DIM_W  = 16;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RD,
        PUSH,
        WAIT_RES,
        WR,
        ADV,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] raddr;
        logic [ADDR_W-1:0] waddr;
        logic [DIM_W-1:0]  width;
        logic [DIM_W-1:0]  height;
    } frame_cfg_t;

endpackage

// File: rtl/edge_frame_sequencer_if.sv
// Memory port and datapath handshake bundle between the sequencer and its neighbours.
interface edge_frame_sequencer_if;
    import edge_pkg::*;

    logic              mem_req;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;

    modport master (
        output mem_req, mem_wr, mem_addr, mem_wdata, pix_valid, pix_data,
        input  mem_rdata, mem_ack, res_valid, res_data
    );

    modport slave (
        input  mem_req, mem_wr, mem_addr, mem_wdata, pix_valid, pix_data,
        output mem_rdata, mem_ack, res_valid, res_data
    );

endinterface

// File: rtl/frame_addr_gen.sv
// Row-major frame walker: x/y counters plus read and write address pointers.
module frame_addr_gen
    import edge_pkg::*;
#(
    parameter int unsigned PIX_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    output logic [ADDR_W-1:0] rd_nxt_c,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              last_pix
);

    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(PIX_BYTES);

    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_nxt;
    logic [DIM_W-1:0]  x;
    logic [DIM_W-1:0]  y;
    logic              x_last;

    assign x_last   = (x == width - DIM_W'(1));
    assign last_pix = x_last && (y == height - DIM_W'(1));

    // Pointer updates wrap modulo 2^ADDR_W by construction.
    always_comb begin
        rd_nxt_c = rd_ptr;
        wr_nxt   = wr_ptr;
        if (load) begin
            rd_nxt_c = raddr;
            wr_nxt   = waddr;
        end else if (advance) begin
            rd_nxt_c = rd_ptr + STRIDE;
            wr_nxt   = wr_ptr + STRIDE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            x      <= '0;
            y      <= '0;
        end else begin
            rd_ptr <= rd_nxt_c;
            wr_ptr <= wr_nxt;
            if (load) begin
                x <= '0;
                y <= '0;
            end else if (advance) begin
                if (x_last) begin
                    x <= '0;
                    y <= y + DIM_W'(1);
                end else begin
                    x <= x + DIM_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/edge_frame_sequencer.sv
// Sequences one frame pixel by pixel: fetch, hand to datapath, await result, write back.
module edge_frame_sequencer
    import edge_pkg::*;
#(
    parameter int unsigned PIX_BYTES   = 4,
    parameter int unsigned RES_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     start_raddr,
    input  logic [ADDR_W-1:0]     start_waddr,
    input  logic [DIM_W-1:0]      img_width,
    input  logic [DIM_W-1:0]      img_height,
    edge_frame_sequencer_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned TO_W = $clog2(RES_TIMEOUT + 1);

    seq_state_t        state, state_d;
    frame_cfg_t        cfg, cfg_d;
    logic [TO_W-1:0]   to_cnt, to_cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              pix_valid_q, pix_valid_d;
    logic [DATA_W-1:0] pix_data_q, pix_data_d;
    logic              busy_d, done_d, err_d;
    logic              cfg_zero_c, load_c, advance_c;
    logic [ADDR_W-1:0] rd_nxt_c;
    logic [ADDR_W-1:0] wr_ptr;
    logic              last_pix;

    assign cfg_zero_c = (cfg.width == '0) || (cfg.height == '0);
    assign load_c     = (state == CHECK) && !cfg_zero_c;
    assign advance_c  = (state == ADV);

    frame_addr_gen #(.PIX_BYTES(PIX_BYTES)) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (load_c),
        .advance  (advance_c),
        .raddr    (cfg.raddr),
        .waddr    (cfg.waddr),
        .width    (cfg.width),
        .height   (cfg.height),
        .rd_nxt_c (rd_nxt_c),
        .wr_ptr   (wr_ptr),
        .last_pix (last_pix)
    );

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_data  = pix_data_q;

    // Next-state logic; every output is the registered image of its _d value.
    always_comb begin
        state_d     = state;
        cfg_d       = cfg;
        to_cnt_d    = to_cnt;
        mem_req_d   = mem_req_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pix_valid_d = 1'b0;
        pix_data_d  = pix_data_q;
        busy_d      = busy;
        done_d      = 1'b0;
        err_d       = err;
        unique case (state)
            IDLE: if (start) begin
                cfg_d   = '{raddr: start_raddr, waddr: start_waddr,
                            width: img_width, height: img_height};
                err_d   = 1'b0;
                busy_d  = 1'b1;
                state_d = CHECK;
            end
            CHECK: if (cfg_zero_c) begin
                err_d   = 1'b1;
                done_d  = 1'b1;
                state_d = DONE;
            end else begin
                mem_req_d  = 1'b1;
                mem_wr_d   = 1'b0;
                mem_addr_d = rd_nxt_c;
                state_d    = RD;
            end
            RD: if (bus.mem_ack) begin
                pix_data_d  = bus.mem_rdata;
                mem_req_d   = 1'b0;
                pix_valid_d = 1'b1;
                state_d     = PUSH;
            end
            PUSH: begin
                to_cnt_d = '0;
                state_d  = WAIT_RES;
            end
            WAIT_RES: if (bus.res_valid) begin
                mem_wdata_d = bus.res_data;
                mem_req_d   = 1'b1;
                mem_wr_d    = 1'b1;
                mem_addr_d  = wr_ptr;
                state_d     = WR;
            end else if (to_cnt == TO_W'(RES_TIMEOUT - 1)) begin
                err_d   = 1'b1;
                done_d  = 1'b1;
                state_d = DONE;
            end else begin
                to_cnt_d = to_cnt + TO_W'(1);
            end
            WR: if (bus.mem_ack) begin
                mem_req_d = 1'b0;
                mem_wr_d  = 1'b0;
                state_d   = ADV;
            end
            ADV: if (last_pix) begin
                done_d  = 1'b1;
                state_d = DONE;
            end else begin
                mem_req_d  = 1'b1;
                mem_addr_d = rd_nxt_c;
                state_d    = RD;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cfg         <= '0;
            to_cnt      <= '0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_d;
            cfg         <= cfg_d;
            to_cnt      <= to_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
        end
    end

endmodule
